synth_ctrl_initiator: RTL and testbench

- CPU-side initiator of the four-phase req/ack transfer into the CPU-to-synth clock-domain crossing.
- The CPU writes synth settings into shadow registers over MMIO, then writes a commit register.
- The block then latches the shadow registers into stable output registers and runs the req/ack handshake with the CDC responder.
- It sits between the CPU MMIO decode and the cpu_carrier_fcws / cpu_mod_fcw / cpu_mod_shift / cpu_note_en / cpu_synth_shift / cpu_req / cpu_ack nets.

---
 rtl/synth_ctrl_initiator.sv | 140 ++++++++++++++
 tb/tb_synth_ctrl_initiator.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/synth_ctrl_initiator.sv
// synth_ctrl_initiator: CPU-side shadow/commit registers and four-phase req/ack initiator into the synth clock domain
// Ports: clk, rst_n (async assert, active-low)
//   mmio_addr/mmio_wdata/mmio_we/mmio_re in, mmio_rdata out (registered, holds when mmio_re is low)
//   cpu_carrier_fcws, cpu_mod_fcw, cpu_mod_shift, cpu_note_en, cpu_synth_shift out: committed settings
//   cpu_req out, cpu_ack in (asynchronous to clk): handshake with the synth-domain responder
// Optional: define SYNTH_CTRL_ACK_TIMEOUT_EN to abort a handshake after ACK_TIMEOUT cycles without an ack edge
module synth_ctrl_initiator #(
    parameter int N_VOICES    = 1,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             mmio_addr,
    input  logic [31:0]            mmio_wdata,
    input  logic                   mmio_we,
    input  logic                   mmio_re,
    output logic [31:0]            mmio_rdata,
    output logic [N_VOICES*24-1:0] cpu_carrier_fcws,
    output logic [23:0]            cpu_mod_fcw,
    output logic [4:0]             cpu_mod_shift,
    output logic [N_VOICES-1:0]    cpu_note_en,
    output logic [4:0]             cpu_synth_shift,
    output logic                   cpu_req,
    input  logic                   cpu_ack
);
    typedef enum logic [1:0] {IDLE, LATCH, REQ, RELEASE} state_t;
    state_t state, state_nx;
    logic [5:0] word;
    logic commit, status_rd, busy, pending, timeout, tmo, ack_s;
    logic [N_VOICES*24-1:0] carr_sh, carr_nx;
    logic [23:0] mod_sh, mod_nx;
    logic [4:0] mshift_sh, mshift_nx, sshift_sh, sshift_nx;
    logic [N_VOICES-1:0] note_sh, note_nx;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic [31:0] rd;
    logic unused_bits;

    assign word        = mmio_addr[7:2];
    assign unused_bits = ^{mmio_addr[1:0], mmio_wdata[31:24]};
    assign commit      = mmio_we && word == 6'h0C;
    assign status_rd   = mmio_re && word == 6'h0D;
    assign busy        = state != IDLE;
    assign cpu_req     = state == REQ;
    assign ack_s       = ack_sync[SYNC_STAGES-1];

    // Next-shadow values double as the LATCH source so a same-cycle write is committed
    for (genvar v = 0; v < N_VOICES; v++) begin : g_voice
        assign carr_nx[24*v +: 24] = (mmio_we && word == 6'(v)) ? mmio_wdata[23:0] : carr_sh[24*v +: 24];
    end
    assign mod_nx    = (mmio_we && word == 6'h08) ? mmio_wdata[23:0] : mod_sh;
    assign mshift_nx = (mmio_we && word == 6'h09) ? mmio_wdata[4:0] : mshift_sh;
    assign note_nx   = (mmio_we && word == 6'h0A) ? mmio_wdata[N_VOICES-1:0] : note_sh;
    assign sshift_nx = (mmio_we && word == 6'h0B) ? mmio_wdata[4:0] : sshift_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ack_sync <= '0;
        else ack_sync <= {ack_sync[SYNC_STAGES-2:0], cpu_ack};
    end

`ifdef SYNTH_CTRL_ACK_TIMEOUT_EN
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt;
    assign tmo = cpu_req || state == RELEASE ? tmo_cnt == CW'(ACK_TIMEOUT - 1) : 1'b0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            tmo_cnt <= (state_nx != state || !(cpu_req || state == RELEASE)) ? '0 : tmo_cnt + 1'b1;
            timeout <= tmo | (timeout & ~status_rd);
        end
    end
`else
    logic [31:0] unused_tmo;
    assign unused_tmo = 32'(ACK_TIMEOUT);
    assign tmo        = 1'b0;
    assign timeout    = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (commit || pending) ? LATCH : IDLE;
            LATCH:   state_nx = REQ;
            REQ:     state_nx = tmo ? IDLE : ack_s ? RELEASE : REQ;
            RELEASE: state_nx = (tmo || !ack_s) ? IDLE : RELEASE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rd = 32'd0;
        for (int i = 0; i < N_VOICES; i++)
            if (word == 6'(i)) rd = 32'(carr_sh[24*i +: 24]);
        case (word)
            6'h08:   rd = 32'(mod_sh);
            6'h09:   rd = 32'(mshift_sh);
            6'h0A:   rd = 32'(note_sh);
            6'h0B:   rd = 32'(sshift_sh);
            6'h0D:   rd = {29'd0, timeout, pending, busy};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            pending          <= 1'b0;
            mmio_rdata       <= 32'd0;
            carr_sh          <= '0;
            mod_sh           <= '0;
            mshift_sh        <= '0;
            note_sh          <= '0;
            sshift_sh        <= '0;
            cpu_carrier_fcws <= '0;
            cpu_mod_fcw      <= '0;
            cpu_mod_shift    <= '0;
            cpu_note_en      <= '0;
            cpu_synth_shift  <= '0;
        end else begin
            state     <= state_nx;
            // IDLE either launches a transfer (consuming pending) or has nothing pending
            pending   <= busy ? (pending | commit) : 1'b0;
            carr_sh   <= carr_nx;
            mod_sh    <= mod_nx;
            mshift_sh <= mshift_nx;
            note_sh   <= note_nx;
            sshift_sh <= sshift_nx;
            if (mmio_re) mmio_rdata <= rd;
            if (state == LATCH) begin
                cpu_carrier_fcws <= carr_nx;
                cpu_mod_fcw      <= mod_nx;
                cpu_mod_shift    <= mshift_nx;
                cpu_note_en      <= note_nx;
                cpu_synth_shift  <= sshift_nx;
            end
        end
    end
endmodule

// File: tb/tb_synth_ctrl_initiator.sv
// tb_synth_ctrl_initiator: directed self-checking bench for synth_ctrl_initiator
module tb_synth_ctrl_initiator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  mmio_addr = 8'd0;
    logic [31:0] mmio_wdata = 32'd0;
    logic        mmio_we = 1'b0;
    logic        mmio_re = 1'b0;
    logic [31:0] mmio_rdata;
    logic [23:0] cpu_carrier_fcws;
    logic [23:0] cpu_mod_fcw;
    logic [4:0]  cpu_mod_shift;
    logic [0:0]  cpu_note_en;
    logic [4:0]  cpu_synth_shift;
    logic        cpu_req;
    logic        cpu_ack = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    synth_ctrl_initiator #(.N_VOICES(1), .SYNC_STAGES(2), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_we(mmio_we), .mmio_re(mmio_re),
        .mmio_rdata(mmio_rdata),
        .cpu_carrier_fcws(cpu_carrier_fcws), .cpu_mod_fcw(cpu_mod_fcw), .cpu_mod_shift(cpu_mod_shift),
        .cpu_note_en(cpu_note_en), .cpu_synth_shift(cpu_synth_shift),
        .cpu_req(cpu_req), .cpu_ack(cpu_ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        mmio_addr  = a;
        mmio_wdata = d;
        mmio_we    = 1'b1;
        tick();
        mmio_we    = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        mmio_addr = a;
        mmio_re   = 1'b1;
        tick();
        mmio_re   = 1'b0;
        chk(tag, mmio_rdata, exp);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        ticks(2);
        chk("rst_req", 32'(cpu_req), 32'h0);
        chk("rst_carrier", 32'(cpu_carrier_fcws), 32'h0);
        chk("rst_mod_fcw", 32'(cpu_mod_fcw), 32'h0);
        chk("rst_mod_shift", 32'(cpu_mod_shift), 32'h0);
        chk("rst_note_en", 32'(cpu_note_en), 32'h0);
        chk("rst_synth_shift", 32'(cpu_synth_shift), 32'h0);
        chk("rst_rdata", mmio_rdata, 32'h0);
        rst_n = 1'b1;
        tick();
        rd_chk("rst_status", 8'h34, 32'h0);

        // first transfer: responder acks 5 cycles after req, releases 5 cycles after req falls
        wr(8'h00, 32'h0012_3456);
        wr(8'h20, 32'h00AB_CDEF);
        wr(8'h24, 32'd3);
        wr(8'h28, 32'd1);
        wr(8'h2C, 32'd2);
        chk("shadow_not_committed", 32'(cpu_carrier_fcws), 32'h0);
        wr(8'h30, 32'hDEAD_BEEF);
        chk("latch_req_low", 32'(cpu_req), 32'h0);
        chk("latch_carrier_old", 32'(cpu_carrier_fcws), 32'h0);
        tick();
        chk("t1_req_high", 32'(cpu_req), 32'h1);
        chk("t1_carrier", 32'(cpu_carrier_fcws), 32'h0012_3456);
        chk("t1_mod_fcw", 32'(cpu_mod_fcw), 32'h00AB_CDEF);
        chk("t1_mod_shift", 32'(cpu_mod_shift), 32'd3);
        chk("t1_note_en", 32'(cpu_note_en), 32'd1);
        chk("t1_synth_shift", 32'(cpu_synth_shift), 32'd2);
        rd_chk("t1_status_busy", 8'h34, 32'h1);
        ticks(4);
        cpu_ack = 1'b1;
        ticks(2);
        chk("t1_req_before_sync", 32'(cpu_req), 32'h1);
        tick();
        chk("t1_req_released", 32'(cpu_req), 32'h0);
        ticks(5);
        cpu_ack = 1'b0;
        rd_chk("t1_status_release_a", 8'h34, 32'h1);
        rd_chk("t1_status_release_b", 8'h34, 32'h1);
        tick();
        rd_chk("t1_status_idle", 8'h34, 32'h0);
        chk("t1_carrier_stable", 32'(cpu_carrier_fcws), 32'h0012_3456);

        // second test: write-through in LATCH, then commits collapse into one pending transfer
        wr(8'h00, 32'h0065_4321);
        wr(8'h30, 32'h0);
        wr(8'h2C, 32'd9);
        chk("t2_req_high", 32'(cpu_req), 32'h1);
        chk("t2_carrier", 32'(cpu_carrier_fcws), 32'h0065_4321);
        chk("t2_write_through", 32'(cpu_synth_shift), 32'd9);
        wr(8'h00, 32'h0000_0111);
        wr(8'h30, 32'h0);
        wr(8'h30, 32'h0);
        rd_chk("t2_status_pending", 8'h34, 32'h3);
        chk("t2_carrier_held", 32'(cpu_carrier_fcws), 32'h0065_4321);
        cpu_ack = 1'b1;
        ticks(3);
        chk("t2_req_released", 32'(cpu_req), 32'h0);
        cpu_ack = 1'b0;
        ticks(3);
        chk("t2_idle_req", 32'(cpu_req), 32'h0);
        chk("t2_idle_carrier", 32'(cpu_carrier_fcws), 32'h0065_4321);
        tick();
        chk("t2_latch2_req", 32'(cpu_req), 32'h0);
        chk("t2_latch2_carrier", 32'(cpu_carrier_fcws), 32'h0065_4321);
        tick();
        chk("t2_req2_high", 32'(cpu_req), 32'h1);
        chk("t2_carrier2", 32'(cpu_carrier_fcws), 32'h0000_0111);
        rd_chk("t2_status_no_pending", 8'h34, 32'h1);
        cpu_ack = 1'b1;
        ticks(3);
        cpu_ack = 1'b0;
        ticks(3);
        ticks(3);
        chk("t2_no_third_req", 32'(cpu_req), 32'h0);
        rd_chk("t2_status_final", 8'h34, 32'h0);

        // decode: ignored writes, truncation, zero reads, read-data hold
        wr(8'h1C, 32'h00FF_FFFF);
        wr(8'h34, 32'h7);
        wr(8'h3C, 32'h1);
        wr(8'h24, 32'hFFFF_FFE5);
        rd_chk("rd_voice1_zero", 8'h1C, 32'h0);
        rd_chk("rd_commit_zero", 8'h30, 32'h0);
        rd_chk("rd_unmapped_zero", 8'h3C, 32'h0);
        rd_chk("rd_mod_shift_trunc", 8'h24, 32'h5);
        rd_chk("rd_carrier0", 8'h03, 32'h0000_0111);
        rd_chk("rd_note_en", 8'h28, 32'h1);
        rd_chk("rd_synth_shift", 8'h2C, 32'd9);
        rd_chk("rd_status_unchanged", 8'h34, 32'h0);
        rd_chk("rd_mod_fcw", 8'h20, 32'h00AB_CDEF);
        mmio_addr = 8'h00;
        ticks(2);
        chk("rdata_hold", mmio_rdata, 32'h00AB_CDEF);
        chk("decode_no_req", 32'(cpu_req), 32'h0);
        chk("decode_mod_shift_committed", 32'(cpu_mod_shift), 32'd3);

        // asynchronous reset mid-handshake with a pending commit
        wr(8'h30, 32'h0);
        tick();
        wr(8'h30, 32'h0);
        chk("ar_req_high", 32'(cpu_req), 32'h1);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_req_drop", 32'(cpu_req), 32'h0);
        chk("ar_carrier_clear", 32'(cpu_carrier_fcws), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        rd_chk("ar_status", 8'h34, 32'h0);
        ticks(3);
        chk("ar_no_pending_req", 32'(cpu_req), 32'h0);
        rd_chk("ar_shadow_clear", 8'h00, 32'h0);

`ifdef SYNTH_CTRL_ACK_TIMEOUT_EN
        wr(8'h30, 32'h0);
        tick();
        chk("to_req_high", 32'(cpu_req), 32'h1);
        ticks(15);
        chk("to_req_last", 32'(cpu_req), 32'h1);
        tick();
        chk("to_req_drop", 32'(cpu_req), 32'h0);
        rd_chk("to_status_sticky", 8'h34, 32'h4);
        rd_chk("to_status_cleared", 8'h34, 32'h0);
`else
        wr(8'h30, 32'h0);
        tick();
        ticks(30);
        chk("wait_req_held", 32'(cpu_req), 32'h1);
        rd_chk("wait_status", 8'h34, 32'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
